mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle main control FSM for the 32-bit RISC core; sits directly upstream of the ALU decoder.
//  Decodes opcode, sequences each instruction through fetch/decode/execute/memory/writeback,
//  drives the datapath enables/muxes and the 2-bit aluop consumed by the ALU decoder.
//  aluop: 00 R-type (funct), 01 slti, 10 beq (sub), 11 add (addi/lw/sw/PC math).
// PARAMETERS
//  OPW       4   opcode width
// PORTS
//  clk        in   1    clock; all state changes on posedge
//  reset      in   1    synchronous, active-high reset
//  op         in   OPW  opcode field of instruction register
//  zero       in   1    ALU zero flag (valid in BEQEX)
//  mem_ready  in   1    memory handshake: current access completes this cycle
//  memwrite   out  1    memory write strobe
//  irwrite    out  1    instruction register load
//  regwrite   out  1    register file write enable
//  iord       out  1    mem addr sel: 0 PC, 1 ALUOut
//  alusrca    out  1    ALU A: 0 PC, 1 rs
//  alusrcb    out  2    ALU B: 00 rt, 01 const 4, 10 signext imm, 11 imm<<2
//  aluop      out  2    to ALU decoder (encoding above)
//  pcsrc      out  2    PC next: 00 ALU result, 01 ALUOut, 10 jump target
//  memtoreg   out  1    RF write data: 0 ALUOut, 1 MDR
//  regdst     out  1    RF dest: 0 rt, 1 rd
//  pcen       out  1    PC load = pcwrite | (branch & zero)
//  illegal_op out  1    1-cycle pulse when DECODE sees unknown opcode
// BEHAVIOUR
//  Opcodes: 0000 R-type, 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 slti, 0110 j; rest illegal.
//  Moore FSM; outputs combinational from state (+mem_ready, zero where noted). Unlisted outputs 0; aluop default 11.
//  reset=1: state<=FETCH next edge; while reset high every enable (memwrite, irwrite, regwrite, pcen, illegal_op) forced 0.
//  FETCH:   iord=0, alusrca=0, alusrcb=01, pcsrc=00; irwrite=pcen=mem_ready. Stay until mem_ready, then DECODE.
//  DECODE:  alusrca=0, alusrcb=11 (branch target precompute). Next by op:
//           lw/sw->MEMADR, R->RTYPEEX, beq->BEQEX, addi->ADDIEX, slti->SLTIEX, j->JEX, illegal->FETCH (+illegal_op=1).
//  MEMADR:  alusrca=1, alusrcb=10 -> lw: MEMRD, sw: MEMWR.
//  MEMRD:   iord=1; wait for mem_ready, then MEMWB.
//  MEMWB:   regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//  MEMWR:   iord=1, memwrite=1 held until mem_ready; mem_ready -> FETCH.
//  RTYPEEX: alusrca=1, alusrcb=00, aluop=00 -> RTYPEWB.
//  RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
//  BEQEX:   alusrca=1, alusrcb=00, aluop=10, pcsrc=01, pcen=zero -> FETCH.
//  ADDIEX:  alusrca=1, alusrcb=10, aluop=11 -> IMMWB.
//  SLTIEX:  alusrca=1, alusrcb=10, aluop=01 -> IMMWB.
//  IMMWB:   regdst=0, memtoreg=0, regwrite=1 -> FETCH.
//  JEX:     pcsrc=10, pcen=1 -> FETCH.
//  Cycles with mem_ready=1 throughout: R 4, lw 5, sw 4, beq 3, addi/slti 4, j 3.
//  Each extra cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle; no enable fires twice.
//  reset mid-instruction: aborts; no partial write issued on the reset cycle; FETCH afterwards.
//  Unreachable state encodings -> FETCH next cycle.
// STRUCTURE
//  ctrl_pkg: opcode localparams, state_t enum, aluop constants (ALUOP_RTYPE/SLTI/BEQ/ADD), alusrcb/pcsrc consts.
//  Sub-module mc_outdec: pure combinational state->control-word decode; mc_controller holds state reg + next-state.
// TESTING
//  reset high 2 cycles, op=0000 -> all enables 0 during reset; 1st cycle after: FETCH, alusrcb=01, aluop=11.
//  R-type op=0000, mem_ready=1 -> states F,D,RTYPEEX(aluop=00),RTYPEWB(regwrite=1,regdst=1); 4 cycles.
//  lw op=0010, mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB memtoreg=1; total 7.
//  beq op=0100: zero=1 -> pcen=1,pcsrc=01 in BEQEX; zero=0 -> pcen=0; both back to FETCH.
//  slti op=0101 -> aluop=01 in SLTIEX, regwrite only in IMMWB; op=1111 -> illegal_op 1 cycle, no writes.
//  sw op=0011, reset asserted in MEMWR -> memwrite=0 that cycle, FETCH next; j op=0110 -> pcsrc=10 in 3rd cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: opcodes, FSM states,
// datapath mux selects and the packed control word produced by the decoder.
package ctrl_pkg;

   localparam int OPW = 4;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_LW    = 4'b0010;
   localparam logic [3:0] OP_SW    = 4'b0011;
   localparam logic [3:0] OP_BEQ   = 4'b0100;
   localparam logic [3:0] OP_SLTI  = 4'b0101;
   localparam logic [3:0] OP_J     = 4'b0110;

   localparam logic [1:0] ALUOP_RTYPE = 2'b00;
   localparam logic [1:0] ALUOP_SLTI  = 2'b01;
   localparam logic [1:0] ALUOP_BEQ   = 2'b10;
   localparam logic [1:0] ALUOP_ADD   = 2'b11;

   localparam logic [1:0] ALUB_RT    = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      SLTIEX  = 4'd10,
      IMMWB   = 4'd11,
      JEX     = 4'd12
   } state_t;

   typedef struct packed {
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       pcen;
      logic       illegal_op;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       memtoreg;
      logic       regdst;
   } ctrl_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_J;
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decode for the multicycle controller.
// Only FETCH (mem_ready), BEQEX (zero) and DECODE (opcode legality) look past the state.
module mc_outdec
   import ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   zero,
   input  logic   op_ok,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl       = '0;
      ctrl.aluop = ALUOP_ADD;
      case (state)
         FETCH: begin
            ctrl.alusrcb = ALUB_FOUR;
            ctrl.pcsrc   = PCSRC_ALU;
            ctrl.irwrite = mem_ready;
            ctrl.pcen    = mem_ready;
         end
         DECODE: begin
            ctrl.alusrcb    = ALUB_IMMSH;
            ctrl.illegal_op = ~op_ok;
         end
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_IMM;
         end
         MEMRD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_RT;
            ctrl.aluop   = ALUOP_RTYPE;
         end
         RTYPEWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         BEQEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_RT;
            ctrl.aluop   = ALUOP_BEQ;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.pcen    = zero;
         end
         ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         SLTIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_IMM;
            ctrl.aluop   = ALUOP_SLTI;
         end
         IMMWB: ctrl.regwrite = 1'b1;
         JEX: begin
            ctrl.pcsrc = PCSRC_JUMP;
            ctrl.pcen  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main control FSM: state register and next-state logic, with the
// control word decoded in mc_outdec and every enable suppressed while reset is high.
module mc_controller
   import ctrl_pkg::*;
#(
   parameter int OPW = 4
)(
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           memwrite,
   output logic           irwrite,
   output logic           regwrite,
   output logic           iord,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [1:0]     pcsrc,
   output logic           memtoreg,
   output logic           regdst,
   output logic           pcen,
   output logic           illegal_op
);

   state_t state_q, state_d;
   ctrl_t  ctrl;
   logic   op_ok;

   assign op_ok = op_legal(op);

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_SLTI:      state_d = SLTIEX;
               OP_J:         state_d = JEX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   if (mem_ready) state_d = MEMWB;
         MEMWR:   if (mem_ready) state_d = FETCH;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX,
         SLTIEX:  state_d = IMMWB;
         MEMWB, RTYPEWB, BEQEX, IMMWB, JEX: state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   mc_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .zero      (zero),
      .op_ok     (op_ok),
      .ctrl      (ctrl)
   );

   // Side-effecting strobes are gated so an aborted instruction cannot write.
   assign memwrite   = ctrl.memwrite   & ~reset;
   assign irwrite    = ctrl.irwrite    & ~reset;
   assign regwrite   = ctrl.regwrite   & ~reset;
   assign pcen       = ctrl.pcen       & ~reset;
   assign illegal_op = ctrl.illegal_op & ~reset;
   assign iord       = ctrl.iord;
   assign alusrca    = ctrl.alusrca;
   assign alusrcb    = ctrl.alusrcb;
   assign aluop      = ctrl.aluop;
   assign pcsrc      = ctrl.pcsrc;
   assign memtoreg   = ctrl.memtoreg;
   assign regdst     = ctrl.regdst;

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller: the driver queues the hand-derived
// control word for every cycle, a negedge monitor pops and compares.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] op = 4'b0000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       memwrite, irwrite, regwrite, iord, alusrca, memtoreg, regdst, pcen, illegal_op;
   logic [1:0] alusrcb, aluop, pcsrc;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [14:0] w;
      logic [14:0] m;
      string       name;
   } exp_t;

   exp_t sb[$];

   localparam logic [14:0] EN_MASK = 15'b11111_00_0000_0000;
   localparam logic [14:0] ALL     = '1;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .iord       (iord),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .aluop      (aluop),
      .pcsrc      (pcsrc),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .pcen       (pcen),
      .illegal_op (illegal_op)
   );

   // Word layout: memwrite irwrite regwrite pcen illegal_op | iord alusrca alusrcb aluop pcsrc memtoreg regdst
   function automatic logic [14:0] mk(input logic mw, ir, rw, pe, il, io, sa,
                                      input logic [1:0] sb_, ao, ps,
                                      input logic mt, rd);
      return {mw, ir, rw, pe, il, io, sa, sb_, ao, ps, mt, rd};
   endfunction

   function automatic logic [14:0] e_fetch(input logic mr);  return mk(0,mr,0,mr,0, 0,0,2'b01,2'b11,2'b00,0,0); endfunction
   function automatic logic [14:0] e_decode(input logic il); return mk(0,0,0,0,il, 0,0,2'b11,2'b11,2'b00,0,0); endfunction
   function automatic logic [14:0] e_memwr(input logic mw);  return mk(mw,0,0,0,0, 1,0,2'b00,2'b11,2'b00,0,0); endfunction
   function automatic logic [14:0] e_beqex(input logic z);   return mk(0,0,0,z,0, 0,1,2'b00,2'b10,2'b01,0,0); endfunction
   localparam logic [14:0] E_MEMADR  = 15'b00000_01_1011_0000;
   localparam logic [14:0] E_MEMRD   = 15'b00000_10_0011_0000;
   localparam logic [14:0] E_MEMWB   = 15'b00100_00_0011_0010;
   localparam logic [14:0] E_RTYPEEX = 15'b00000_01_0000_0000;
   localparam logic [14:0] E_RTYPEWB = 15'b00100_00_0011_0001;
   localparam logic [14:0] E_ADDIEX  = 15'b00000_01_1011_0000;
   localparam logic [14:0] E_SLTIEX  = 15'b00000_01_1001_0000;
   localparam logic [14:0] E_IMMWB   = 15'b00100_00_0011_0000;
   localparam logic [14:0] E_JEX     = 15'b00010_00_0011_1000;

   task automatic applyStimulus(input logic rst, input logic [3:0] o, input logic mr, input logic z,
                                input logic [14:0] w, input string name, input logic [14:0] m = ALL);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      op = o;
      mem_ready = mr;
      zero = z;
      e.w = w;
      e.m = m;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      logic [14:0] act;
      e = sb.pop_front();
      act = {memwrite, irwrite, regwrite, pcen, illegal_op, iord, alusrca, alusrcb, aluop, pcsrc, memtoreg, regdst};
      checks++;
      if ((act & e.m) !== (e.w & e.m)) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b (mask %b)", e.name, act, e.w, e.m);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) checkOutput();
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset with mem_ready high: FETCH's irwrite/pcen must stay masked.
      applyStimulus(1, 4'b0000, 1, 0, '0, "reset_enables", EN_MASK);
      applyStimulus(1, 4'b0000, 1, 0, mk(0,0,0,0,0, 0,0,2'b01,2'b11,2'b00,0,0), "reset_fetch");

      // R-type: 4 cycles
      applyStimulus(0, 4'b0000, 1, 0, e_fetch(1),  "r_fetch");
      applyStimulus(0, 4'b0000, 1, 0, e_decode(0), "r_decode");
      applyStimulus(0, 4'b0000, 1, 0, E_RTYPEEX,   "r_ex");
      applyStimulus(0, 4'b0000, 1, 0, E_RTYPEWB,   "r_wb");

      // lw with two stall cycles in MEMRD: 7 cycles
      applyStimulus(0, 4'b0010, 1, 0, e_fetch(1),  "lw_fetch");
      applyStimulus(0, 4'b0010, 1, 0, e_decode(0), "lw_decode");
      applyStimulus(0, 4'b0010, 1, 0, E_MEMADR,    "lw_memadr");
      applyStimulus(0, 4'b0010, 0, 0, E_MEMRD,     "lw_memrd0");
      applyStimulus(0, 4'b0010, 0, 0, E_MEMRD,     "lw_memrd1");
      applyStimulus(0, 4'b0010, 1, 0, E_MEMRD,     "lw_memrd2");
      applyStimulus(0, 4'b0010, 1, 0, E_MEMWB,     "lw_memwb");

      // beq taken then not taken
      applyStimulus(0, 4'b0100, 1, 1, e_fetch(1),  "beqt_fetch");
      applyStimulus(0, 4'b0100, 1, 1, e_decode(0), "beqt_decode");
      applyStimulus(0, 4'b0100, 1, 1, e_beqex(1),  "beqt_ex");
      applyStimulus(0, 4'b0100, 1, 0, e_fetch(1),  "beqn_fetch");
      applyStimulus(0, 4'b0100, 1, 0, e_decode(0), "beqn_decode");
      applyStimulus(0, 4'b0100, 1, 0, e_beqex(0),  "beqn_ex");

      // slti, then addi with one FETCH stall
      applyStimulus(0, 4'b0101, 1, 0, e_fetch(1),  "slti_fetch");
      applyStimulus(0, 4'b0101, 1, 0, e_decode(0), "slti_decode");
      applyStimulus(0, 4'b0101, 1, 0, E_SLTIEX,    "slti_ex");
      applyStimulus(0, 4'b0101, 1, 0, E_IMMWB,     "slti_wb");
      applyStimulus(0, 4'b0001, 0, 0, e_fetch(0),  "addi_fetch_stall");
      applyStimulus(0, 4'b0001, 1, 0, e_fetch(1),  "addi_fetch");
      applyStimulus(0, 4'b0001, 1, 0, e_decode(0), "addi_decode");
      applyStimulus(0, 4'b0001, 1, 0, E_ADDIEX,    "addi_ex");
      applyStimulus(0, 4'b0001, 1, 0, E_IMMWB,     "addi_wb");

      // Illegal opcode: single-cycle pulse, straight back to FETCH
      applyStimulus(0, 4'b1111, 1, 0, e_fetch(1),  "ill_fetch");
      applyStimulus(0, 4'b1111, 1, 0, e_decode(1), "ill_decode");

      // sw aborted by reset while in MEMWR
      applyStimulus(0, 4'b0011, 1, 0, e_fetch(1),  "swr_fetch");
      applyStimulus(0, 4'b0011, 1, 0, e_decode(0), "swr_decode");
      applyStimulus(0, 4'b0011, 1, 0, E_MEMADR,    "swr_memadr");
      applyStimulus(0, 4'b0011, 0, 0, e_memwr(1),  "swr_memwr");
      applyStimulus(1, 4'b0011, 0, 0, e_memwr(0),  "swr_reset");

      // j: jump in 3rd cycle
      applyStimulus(0, 4'b0110, 1, 0, e_fetch(1),  "j_fetch");
      applyStimulus(0, 4'b0110, 1, 0, e_decode(0), "j_decode");
      applyStimulus(0, 4'b0110, 1, 0, E_JEX,       "j_ex");

      // sw uninterrupted: 4 cycles
      applyStimulus(0, 4'b0011, 1, 0, e_fetch(1),  "sw_fetch");
      applyStimulus(0, 4'b0011, 1, 0, e_decode(0), "sw_decode");
      applyStimulus(0, 4'b0011, 1, 0, E_MEMADR,    "sw_memadr");
      applyStimulus(0, 4'b0011, 1, 0, e_memwr(1),  "sw_memwr");
      applyStimulus(0, 4'b0000, 0, 0, e_fetch(0),  "final_fetch");

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
